rr_arb8_ctrl: RTL and testbench

//  8-way round-robin arbiter for one shared resource. Up to 8 requesters compete.
//  The winner index drives a 3x8 enable-decoder sub-module, which produces the one-hot grant bus.
//  A grant is held until the owner drops its request or a hold timeout expires.
//  The arbiter then rotates priority to the requester after the owner.

---
 rtl/arb_pkg.sv | 34 +++
 rtl/dec3to8_en.sv | 20 ++
 rtl/rr_arb8_ctrl.sv | 112 +++++++++++
 tb/tb_rr_arb8_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Rotate req right by ptr, take the lowest set bit, add ptr back (3-bit wrap).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0] ptr_v);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   k;
    logic               found;
    dbl   = {req_v, req_v} >> ptr_v;
    rot   = dbl[N_REQ-1:0];
    k     = {IDX_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        k     = i[IDX_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return ptr_v + k;
  endfunction

endpackage

// File: rtl/dec3to8_en.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero when disabled.
module dec3to8_en
  import arb_pkg::*;
(
  output logic [N_REQ-1:0] y,
  input  logic             En,
  input  logic [IDX_W-1:0] I
);

  // One-hot decode of I gated by En
  always_comb begin
    y = {N_REQ{1'b0}};
    if (En) begin
      y[I] = 1'b1;
    end else begin
      y = {N_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// 8-way round-robin arbiter: grants one requester at a time, holds until release
// or hold timeout, then rotates priority to the requester after the owner.
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int               HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             TO_EN       = (MAX_HOLD != 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vld_q, vld_d;
  logic               to_q, to_d;
  logic [IDX_W-1:0]   pick_s;

  assign pick_s = rr_pick(req, ptr_q);

  // Next-state logic; vld_d/owner_d describe the grant visible after the next edge
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    vld_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (En && (req != {N_REQ{1'b0}})) begin
          owner_d = pick_s;
          hold_d  = {CNT_W{1'b0}};
          state_d = ST_GRANT;
          vld_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Release wins over a coincident timeout
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q + 3'd1;
        end else if (TO_EN && (hold_q == HOLD_LAST)) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q + 3'd1;
          to_d    = 1'b1;
        end else begin
          vld_d  = 1'b1;
          hold_d = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  dec3to8_en u_dec (
    .y  (gnt_d),
    .En (vld_d),
    .I  (owner_d)
  );

  assign idx_d = vld_d ? owner_d : {IDX_W{1'b0}};

  // State, pointer, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= {IDX_W{1'b0}};
      ptr_q   <= {IDX_W{1'b0}};
      hold_q  <= {CNT_W{1'b0}};
      gnt_q   <= {N_REQ{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Self-checking bench for rr_arb8_ctrl: directed steps plus randomized traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_rr_arb8_ctrl;

  localparam int TB_MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic       En;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int passed;
  int total;

  // Reference model state: owner=-1 means nobody holds the resource
  int         m_owner;
  int         m_ptr;
  int         m_held;
  logic [7:0] e_gnt;
  logic [2:0] e_idx;
  logic       e_vld;
  logic       e_to;

  rr_arb8_ctrl #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .En      (En),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input logic r, input logic e, input logic [7:0] q);
    e_to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (e && q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (q[c]) begin
            m_owner = c;
            break;
          end
        end
        m_held = 1;
      end
    end else if (!q[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (TB_MAX_HOLD != 0 && m_held == TB_MAX_HOLD) begin
      e_to    = 1'b1;
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
      m_held++;
    end
    e_gnt = 8'h00;
    e_idx = 3'd0;
    e_vld = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_idx = 3'(m_owner);
      e_vld = 1'b1;
    end
  endtask

  // One clock: apply inputs, advance model at the edge, check outputs 1 time unit later
  task automatic cyc(input logic r, input logic e, input logic [7:0] q);
    rst = r;
    En  = e;
    req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
    chk("gnt", gnt, e_gnt);
    chk("gnt_idx", {5'd0, gnt_idx}, {5'd0, e_idx});
    chk("gnt_vld", {7'd0, gnt_vld}, {7'd0, e_vld});
    chk("timeout", {7'd0, timeout}, {7'd0, e_to});
    chk("vld_vs_gnt", {7'd0, gnt_vld}, {7'd0, |gnt});
  endtask

  initial begin
    logic [7:0] mask;
    logic [7:0] rq;
    passed  = 0;
    total   = 0;
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    rst = 1'b1;
    En  = 1'b0;
    req = 8'h00;

    // Reset state
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);

    // Single requester grant and release
    cyc(1'b0, 1'b1, 8'h01);
    chk("t1_gnt", gnt, 8'h01);
    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h00);
    chk("t1_drop", gnt, 8'h00);

    // Full rotation with all requesters active
    cyc(1'b1, 1'b0, 8'h00);
    for (int o = 0; o < 9; o++) begin
      mask = 8'h01 << (o % 8);
      cyc(1'b0, 1'b1, 8'hFF);
      chk("t2_order", {5'd0, gnt_idx}, 8'(o % 8));
      cyc(1'b0, 1'b1, 8'hFF);
      cyc(1'b0, 1'b1, 8'hFF & ~mask);
      chk("t2_gap", gnt, 8'h00);
    end

    // Pointer wrap past 7
    cyc(1'b0, 1'b1, 8'h04);
    chk("t3_g2", gnt, 8'h04);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h81);
    chk("t3_g7", gnt, 8'h80);
    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h01);
    chk("t3_wrap", gnt, 8'h01);
    cyc(1'b0, 1'b1, 8'h00);

    // Hold timeout
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h60);
      chk("t4_hold", gnt, 8'h20);
    end
    cyc(1'b0, 1'b1, 8'h60);
    chk("t4_to", {7'd0, timeout}, 8'h01);
    chk("t4_to_gnt", gnt, 8'h00);
    cyc(1'b0, 1'b1, 8'h60);
    chk("t4_next", gnt, 8'h40);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h60);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);

    // Reset during grant
    cyc(1'b0, 1'b1, 8'h08);
    cyc(1'b1, 1'b1, 8'h08);
    chk("t5_rst", gnt, 8'h00);
    cyc(1'b0, 1'b1, 8'h0C);
    chk("t5_idx", {5'd0, gnt_idx}, 8'd2);
    cyc(1'b0, 1'b1, 8'h00);

    // Enable blocks new grants only
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h10);
      chk("t6_blocked", gnt, 8'h00);
    end
    cyc(1'b0, 1'b1, 8'h10);
    chk("t6_gnt", gnt, 8'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h10);
      chk("t6_persist", gnt, 8'h10);
    end
    cyc(1'b0, 1'b0, 8'h00);

    // Randomized traffic against the model
    rq = 8'($urandom);
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      end
      if ($urandom_range(0, 49) == 0) rq = 8'($urandom);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rq);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
